uart_word_packer: RTL and testbench

Bridges the byte-wide UART front end and the word-wide crypter core. Collects bytes from the UART receive interface into a `WORD_BYTES`-byte word, most significant byte first, and hands the word to the crypter over a valid/ready handshake. Accepts the crypter's result word over a second valid/ready handshake and serializes it back to the UART transmitter, one byte per `tx_start`/`tx_busy` cycle.

---
 rtl/uart_packer_pkg.sv | 23 ++
 rtl/uart_word_serializer.sv | 78 +++++++
 rtl/uart_word_packer.sv | 119 +++++++++++
 tb/tb_uart_word_packer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_packer_pkg.sv
// Shared types and helpers for the UART word packer and its serializer.
package uart_packer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        RX_COLLECT,
        RX_GAP,
        RX_HOLD
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_ARM,
        TX_WAIT
    } tx_state_e;

    function automatic int cnt_width(input int nbytes);
        return $clog2(nbytes + 1);
    endfunction

endpackage

// File: rtl/uart_word_serializer.sv
// Latches a result word and sends it MSB-first to the UART transmitter,
// one byte per tx_start / tx_busy cycle.
module uart_word_serializer
    import uart_packer_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    localparam int W = BYTE_W * WORD_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      result_in,
    input  logic              result_valid,
    output logic              result_ready,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_busy
);

    localparam int CW = cnt_width(WORD_BYTES);

    tx_state_e         state_q;
    logic [W-1:0]      latch_q;
    logic [CW-1:0]     cnt_q;
    logic              ready_q;
    logic              start_q;
    logic [BYTE_W-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TX_IDLE;
            latch_q <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            start_q <= 1'b0;
            data_q  <= '0;
        end else begin
            start_q <= 1'b0;
            unique case (state_q)
                TX_IDLE: begin
                    if (result_valid) begin
                        latch_q <= result_in;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= TX_START;
                    end
                end
                TX_START: begin
                    data_q  <= latch_q[W-1 -: BYTE_W];
                    start_q <= 1'b1;
                    state_q <= TX_ARM;
                end
                // Advance unconditionally so a silent transmitter cannot wedge us.
                TX_ARM: begin
                    state_q <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (!tx_busy) begin
                        latch_q <= latch_q << BYTE_W;
                        if (cnt_q == CW'(WORD_BYTES - 1)) begin
                            cnt_q   <= '0;
                            ready_q <= 1'b1;
                            state_q <= TX_IDLE;
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                            state_q <= TX_START;
                        end
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

    assign result_ready = ready_q;
    assign tx_start     = start_q;
    assign tx_data      = data_q;

endmodule

// File: rtl/uart_word_packer.sv
// Packs UART bytes MSB-first into words and serializes result words back out.
// Optional inter-byte timeout is built when PACKER_TIMEOUT_EN is defined.
module uart_word_packer
    import uart_packer_pkg::*;
#(
    parameter int WORD_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    localparam int W = BYTE_W * WORD_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_readable,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              rx_used_tick,
    output logic [W-1:0]      word_out,
    output logic              word_valid,
    input  logic              word_ready,
    input  logic [W-1:0]      result_in,
    input  logic              result_valid,
    output logic              result_ready,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_busy
);

    localparam int CW = cnt_width(WORD_BYTES);

    generate
        if (WORD_BYTES < 2 || WORD_BYTES > 64 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
            $error("uart_word_packer: parameter out of range");
        end
    endgenerate

    rx_state_e     state_q;
    logic [W-1:0]  shift_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  word_q;
    logic          valid_q;
    logic          tick_q;

`ifdef PACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RX_COLLECT;
            shift_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            tick_q  <= 1'b0;
`ifdef PACKER_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            tick_q <= 1'b0;
            unique case (state_q)
                RX_COLLECT: begin
                    if (rx_readable) begin
                        shift_q <= {shift_q[W-BYTE_W-1:0], rx_data};
                        tick_q  <= 1'b1;
                        cnt_q   <= cnt_q + 1'b1;
                        state_q <= RX_GAP;
`ifdef PACKER_TIMEOUT_EN
                        tmo_q   <= '0;
                    end else if (cnt_q != '0) begin
                        // Stale partial word: drop it rather than mix with the next burst.
                        if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                            shift_q <= '0;
                            cnt_q   <= '0;
                            tmo_q   <= '0;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
`endif
                    end
                end
                // Dead cycle lets the UART clear its readable flag.
                RX_GAP: begin
                    if (cnt_q == CW'(WORD_BYTES)) begin
                        word_q  <= shift_q;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= RX_HOLD;
                    end else begin
                        state_q <= RX_COLLECT;
                    end
                end
                RX_HOLD: begin
                    if (valid_q && word_ready) begin
                        valid_q <= 1'b0;
                        state_q <= RX_COLLECT;
                    end
                end
                default: state_q <= RX_COLLECT;
            endcase
        end
    end

    assign rx_used_tick = tick_q;
    assign word_out     = word_q;
    assign word_valid   = valid_q;

    uart_word_serializer #(
        .WORD_BYTES(WORD_BYTES)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .result_in   (result_in),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy)
    );

endmodule

// File: tb/tb_uart_word_packer.sv
// Directed bench for uart_word_packer with a queue-based reference model.
module tb_uart_word_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_readable = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_used_tick;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] result_in;
    logic        result_valid;
    logic        result_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0]  rxq[$];
    logic [7:0]  part[$];
    logic [31:0] exp_words[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  tx_log[$];
    int          used_cnt = 0;
    int          words_seen = 0;
    int          wv_cycles = 0;
    int          acc_cnt = 0;
    int          busy_cnt = 0;
    int          busy_len = 100;
    logic [7:0]  cur_tx = 8'h00;
    logic [31:0] last_word = 32'h0;

    always #5 clk = ~clk;

    uart_word_packer #(
        .WORD_BYTES(4)
`ifdef PACKER_TIMEOUT_EN
        , .TIMEOUT_CYCLES(50)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_readable (rx_readable),
        .rx_data     (rx_data),
        .rx_used_tick(rx_used_tick),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .result_in   (result_in),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Environment (UART rx/tx peers) plus reference model, sampled on negedge.
    always @(negedge clk) begin
        if (rst) begin
            part.delete();
            exp_words.delete();
            exp_tx.delete();
        end else begin
            if (word_valid) begin
                wv_cycles++;
                if (exp_words.size() == 0) begin
                    chk("word_spurious", 1, 0);
                end else begin
                    chk("word_out", word_out, exp_words[0]);
                    if (word_ready) begin
                        void'(exp_words.pop_front());
                        words_seen++;
                        last_word = word_out;
                    end
                end
            end
            if (rx_used_tick) begin
                if (rxq.size() == 0) begin
                    chk("rx_tick_spurious", 1, 0);
                end else begin
                    part.push_back(rxq.pop_front());
                    used_cnt++;
                    if (part.size() == 4) begin
                        exp_words.push_back({part[0], part[1], part[2], part[3]});
                        part.delete();
                    end
                end
            end
            if (busy_cnt > 0)
                chk("tx_data_stable", tx_data, cur_tx);
            if (exp_tx.size() > 0 || busy_cnt > 0)
                chk("result_ready_low", result_ready, 0);
            if (tx_start) begin
                if (exp_tx.size() == 0) begin
                    chk("tx_start_spurious", 1, 0);
                end else begin
                    chk("tx_byte", tx_data, exp_tx.pop_front());
                end
                tx_log.push_back(tx_data);
                cur_tx = tx_data;
                busy_cnt = busy_len;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            if (result_valid && result_ready) begin
                for (int i = 3; i >= 0; i--)
                    exp_tx.push_back(result_in[i*8 +: 8]);
                acc_cnt++;
            end
        end
        if (rst && busy_cnt > 0)
            busy_cnt--;
        tx_busy = (busy_cnt > 0);
        rx_readable = (rxq.size() > 0);
        rx_data = (rxq.size() > 0) ? rxq[0] : 8'h00;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push4(input logic [31:0] w);
        for (int i = 3; i >= 0; i--)
            rxq.push_back(w[i*8 +: 8]);
    endtask

    task automatic wait_words(input int target, input string name);
        for (int i = 0; i < 2000 && words_seen < target; i++)
            step(1);
        chk(name, words_seen >= target, 1);
    endtask

    task automatic wait_used(input int target, input string name);
        for (int i = 0; i < 2000 && used_cnt < target; i++)
            step(1);
        chk(name, used_cnt >= target, 1);
    endtask

    task automatic wait_tx_done(input string name);
        for (int i = 0; i < 3000 && !(tx_log.size() == 4 && result_ready && busy_cnt == 0); i++)
            step(1);
        chk(name, tx_log.size(), 4);
    endtask

    task automatic send_result(input logic [31:0] w);
        int base;
        base = acc_cnt;
        result_in = w;
        result_valid = 1'b1;
        for (int i = 0; i < 500 && acc_cnt == base; i++)
            step(1);
        chk("result_accept", acc_cnt != base, 1);
        result_valid = 1'b0;
    endtask

    initial begin
        int base;
        rst = 1'b1;
        word_ready = 1'b0;
        result_in = 32'h0;
        result_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_used_tick", rx_used_tick, 0);
        chk("rst_word_out", word_out, 0);
        chk("rst_word_valid", word_valid, 0);
        chk("rst_result_ready", result_ready, 1);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        step(1);
        rst = 1'b0;
        step(2);

        // Basic word, consumer always ready
        word_ready = 1'b1;
        wv_cycles = 0;
        push4(32'hDEADBEEF);
        wait_words(1, "word1_timeout");
        chk("word1_value", last_word, 32'hDEADBEEF);
        chk("word1_ticks", used_cnt, 4);
        step(5);
        chk("word1_valid_cycles", wv_cycles, 1);

        // Backpressure: fifth byte must stay unconsumed while word is held
        word_ready = 1'b0;
        push4(32'h11223344);
        rxq.push_back(8'h55);
        step(40);
        chk("hold_ticks", used_cnt, 8);
        chk("hold_valid", word_valid, 1);
        chk("hold_word", word_out, 32'h11223344);
        word_ready = 1'b1;
        wait_words(2, "word2_timeout");
        chk("word2_value", last_word, 32'h11223344);
        step(10);
        chk("fifth_consumed", used_cnt, 9);
        rxq.push_back(8'h66);
        rxq.push_back(8'h77);
        rxq.push_back(8'h88);
        wait_words(3, "word3_timeout");
        chk("word3_value", last_word, 32'h55667788);

        // Result serialization with a slow transmitter
        tx_log.delete();
        busy_len = 100;
        send_result(32'h01020304);
        wait_tx_done("tx1_timeout");
        chk("tx1_bytes", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'h01020304);
        step(2);
        chk("tx1_ready_back", result_ready, 1);

        // Reset in the middle of a word
        base = used_cnt;
        rxq.push_back(8'hAA);
        rxq.push_back(8'hBB);
        wait_used(base + 2, "partial_timeout");
        step(1);
        rst = 1'b1;
        step(1);
        chk("midrst_valid", word_valid, 0);
        chk("midrst_tick", rx_used_tick, 0);
        step(1);
        rst = 1'b0;
        step(2);
        push4(32'h12345678);
        wait_words(4, "word4_timeout");
        chk("word4_value", last_word, 32'h12345678);

`ifdef PACKER_TIMEOUT_EN
        base = used_cnt;
        rxq.push_back(8'h9A);
        rxq.push_back(8'hBC);
        wait_used(base + 2, "tmo_partial_timeout");
        step(60);
        chk("tmo_no_word", words_seen, 4);
        part.delete();
        push4(32'hC1C2C3C4);
        wait_words(5, "tmo_word_timeout");
        chk("tmo_word_value", last_word, 32'hC1C2C3C4);
`endif

        // Concurrent receive and transmit
        base = words_seen;
        tx_log.delete();
        busy_len = 5;
        push4(32'hF0F1F2F3);
        send_result(32'hA1B2C3D4);
        wait_words(base + 1, "conc_word_timeout");
        chk("conc_word_value", last_word, 32'hF0F1F2F3);
        wait_tx_done("conc_tx_timeout");
        chk("conc_tx_bytes", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'hA1B2C3D4);

        step(5);
        chk("end_words_drained", exp_words.size(), 0);
        chk("end_tx_drained", exp_tx.size(), 0);
        chk("end_result_ready", result_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
